// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared types, widths and helpers for the MEM/WB stage
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Number of word-index bits needed to address a memory of the given depth.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// rtl/mem_wb_stage_data_mem.sv - word-addressed data memory, sync write / comb read
module data_mem
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; a write lands on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    // Read is combinational, so a load sees the value from before a same-edge write.
    assign rdata = r_mem[idx];

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage plus MEM/WB register; MEM_STATS_EN adds load/store counters
module mem_wb_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_DEPTH   = 64,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              MemToReg,
    input  logic [DATA_W-1:0] ALUresult,
    input  logic [DATA_W-1:0] RtData,
    input  logic [REG_W-1:0]  RdAddr,
    output logic              stall,
    output logic              RegWrite_out,
    output logic              MemToReg_out,
    output logic [DATA_W-1:0] ReadData_out,
    output logic [DATA_W-1:0] ALUresult_out,
    output logic [REG_W-1:0]  RdAddr_out
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]       load_count,
    output logic [31:0]       store_count
`endif
);

    localparam int             IDX_W  = idx_width(MEM_DEPTH);
    localparam bit             LAT_NZ = (MEM_LATENCY != 0);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT_NZ ? MEM_LATENCY - 1 : 0);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_memop;
    logic               w_complete;
    logic               w_stall;
    logic               w_is_load;
    logic               w_we;
    logic [IDX_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_rdata;

    assign w_memop   = MemRead | MemWrite;
    // A both-high op is a store; only a pure read counts as a load.
    assign w_is_load = MemRead & ~MemWrite;
    // Upper address bits are dropped so accesses wrap modulo the depth.
    assign w_idx     = ALUresult[IDX_W+1:2];
    // Gate with reset so an op held upstream cannot write while reset is asserted.
    assign w_we      = w_complete & MemWrite & rst_n;
    assign stall     = w_stall;

    data_mem #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_data_mem (
        .clk   (clk),
        .we    (w_we),
        .idx   (w_idx),
        .wdata (RtData),
        .rdata (w_rdata)
    );

    // FSM state and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: a memory op waits MEM_LATENCY stalled cycles, then completes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_memop && LAT_NZ) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = LAT_M1;
                    w_stall     = 1'b1;
                end else begin
                    w_complete  = 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                    w_stall     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // MEM/WB register: capture the instruction on completion, otherwise insert a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite_out  <= 1'b0;
            MemToReg_out  <= 1'b0;
            ReadData_out  <= '0;
            ALUresult_out <= '0;
            RdAddr_out    <= '0;
        end else if (w_complete) begin
            RegWrite_out  <= RegWrite;
            MemToReg_out  <= MemToReg;
            ReadData_out  <= w_is_load ? w_rdata : '0;
            ALUresult_out <= ALUresult;
            RdAddr_out    <= RdAddr;
        end else begin
            RegWrite_out  <= 1'b0;
            MemToReg_out  <= 1'b0;
        end
    end

`ifdef MEM_STATS_EN
    logic [31:0] r_load_count;
    logic [31:0] r_store_count;

    // Saturating counters of completed loads and stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_count  <= '0;
            r_store_count <= '0;
        end else if (w_complete) begin
            if (MemWrite && (r_store_count != 32'hFFFF_FFFF)) begin
                r_store_count <= r_store_count + 32'd1;
            end
            if (w_is_load && (r_load_count != 32'hFFFF_FFFF)) begin
                r_load_count <= r_load_count + 32'd1;
            end
        end
    end

    assign load_count  = r_load_count;
    assign store_count = r_store_count;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage (latency 2 and 0)
module tb_mem_wb_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rw [2], mw [2], mr [2], mtr [2];
    logic [31:0] alu [2], rt [2];
    logic [4:0]  rda [2];
    logic        st [2], rwo [2], mtro [2];
    logic [31:0] rdo [2], aluo [2];
    logic [4:0]  rdao [2];
`ifdef MEM_STATS_EN
    logic [31:0] lc [2], sc [2];
`endif

    mem_wb_stage #(.MEM_DEPTH(64), .MEM_LATENCY(2)) u_dut_lat2 (
        .clk(clk), .rst_n(rst_n),
        .RegWrite(rw[0]), .MemWrite(mw[0]), .MemRead(mr[0]), .MemToReg(mtr[0]),
        .ALUresult(alu[0]), .RtData(rt[0]), .RdAddr(rda[0]),
        .stall(st[0]), .RegWrite_out(rwo[0]), .MemToReg_out(mtro[0]),
        .ReadData_out(rdo[0]), .ALUresult_out(aluo[0]), .RdAddr_out(rdao[0])
`ifdef MEM_STATS_EN
        , .load_count(lc[0]), .store_count(sc[0])
`endif
    );

    mem_wb_stage #(.MEM_DEPTH(64), .MEM_LATENCY(0)) u_dut_lat0 (
        .clk(clk), .rst_n(rst_n),
        .RegWrite(rw[1]), .MemWrite(mw[1]), .MemRead(mr[1]), .MemToReg(mtr[1]),
        .ALUresult(alu[1]), .RtData(rt[1]), .RdAddr(rda[1]),
        .stall(st[1]), .RegWrite_out(rwo[1]), .MemToReg_out(mtro[1]),
        .ReadData_out(rdo[1]), .ALUresult_out(aluo[1]), .RdAddr_out(rdao[1])
`ifdef MEM_STATS_EN
        , .load_count(lc[1]), .store_count(sc[1])
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: memory image plus expected WB register contents, per DUT.
    logic [31:0] m_mem [2][64];
    bit          m_vld [2][64];
    logic        e_rw [2], e_mtr [2];
    logic [31:0] e_rd [2], e_alu [2];
    logic [4:0]  e_rda [2];
    bit          e_rd_known [2];
    int          m_loads [2], m_stores [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input int s, input string tag);
        check_eq({tag, ".RegWrite_out"}, 32'(rwo[s]), 32'(e_rw[s]));
        check_eq({tag, ".MemToReg_out"}, 32'(mtro[s]), 32'(e_mtr[s]));
        check_eq({tag, ".ALUresult_out"}, aluo[s], e_alu[s]);
        check_eq({tag, ".RdAddr_out"}, 32'(rdao[s]), 32'(e_rda[s]));
        if (e_rd_known[s]) check_eq({tag, ".ReadData_out"}, rdo[s], e_rd[s]);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            e_rw[s] = 0; e_mtr[s] = 0; e_rd[s] = 0; e_alu[s] = 0; e_rda[s] = 0;
            e_rd_known[s] = 1; m_loads[s] = 0; m_stores[s] = 0;
        end
    endtask

    task automatic drive(input int s, input logic i_rw, input logic i_mw, input logic i_mr,
                         input logic i_mtr, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r);
        rw[s] = i_rw; mw[s] = i_mw; mr[s] = i_mr; mtr[s] = i_mtr;
        alu[s] = a; rt[s] = d; rda[s] = r;
    endtask

    // Issue one instruction (called at posedge+1) and follow it to completion.
    task automatic exec(input int s, input logic i_rw, input logic i_mw, input logic i_mr,
                        input logic i_mtr, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] r);
        int lat;
        int idx;
        lat = (s == 0) ? 2 : 0;
        idx = int'((a / 4) % 64);
        drive(s, i_rw, i_mw, i_mr, i_mtr, a, d, r);
        if (i_mw || i_mr) begin
            for (int c = 0; c < lat; c++) begin
                #1 check_eq("stall_high", 32'(st[s]), 32'd1);
                @(posedge clk); #1;
                e_rw[s] = 0; e_mtr[s] = 0;
                check_outs(s, "bubble");
            end
        end
        #1 check_eq("stall_low", 32'(st[s]), 32'd0);
        @(posedge clk);
        e_rw[s] = i_rw; e_mtr[s] = i_mtr; e_alu[s] = a; e_rda[s] = r;
        if (i_mw) begin
            m_mem[s][idx] = d; m_vld[s][idx] = 1;
            e_rd[s] = 0; e_rd_known[s] = 1; m_stores[s]++;
        end else if (i_mr) begin
            e_rd[s] = m_mem[s][idx]; e_rd_known[s] = m_vld[s][idx]; m_loads[s]++;
        end else begin
            e_rd[s] = 0; e_rd_known[s] = 1;
        end
        #1 check_outs(s, "done");
    endtask

    // Zero a DUT's inputs so it idles on NOPs while the other DUT is exercised.
    task automatic park(input int s);
        drive(s, 0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
        @(posedge clk); #1;
        e_rw[s] = 0; e_mtr[s] = 0; e_rd[s] = 0; e_alu[s] = 0; e_rda[s] = 0; e_rd_known[s] = 1;
    endtask

    task automatic rand_op(input int s);
        int kind;
        logic [31:0] a, d;
        kind = $urandom_range(0, 3);
        a = $urandom; d = $urandom;
        case (kind)
            0: exec(s, 1'($urandom), 0, 0, 0, a, d, 5'($urandom));
            1: exec(s, 1, 0, 1, 1, a, d, 5'($urandom));
            2: exec(s, 0, 1, 0, 0, a, d, 5'($urandom));
            default: exec(s, 0, 1, 1, 0, a, d, 5'($urandom));
        endcase
    endtask

    initial begin
        rst_n = 0;
        for (int s = 0; s < 2; s++) drive(s, 0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check_outs(s, "reset");
            check_eq("reset.stall", 32'(st[s]), 32'd0);
        end
        rst_n = 1;

        // ALU op passes through in one cycle
        exec(0, 1, 0, 0, 0, 32'h1234, 32'h0, 5'd5);
        // store then load with latency 2
        exec(0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        exec(0, 1, 0, 1, 1, 32'h10, 32'h0, 5'd3);
        // address wrap and ignored low bits
        exec(0, 0, 1, 0, 0, 32'h104, 32'hA5A5A5A5, 5'd0);
        exec(0, 1, 0, 1, 1, 32'h4, 32'h0, 5'd4);
        exec(0, 1, 0, 1, 1, 32'h7, 32'h0, 5'd6);
        // both-high acts as a store
        exec(0, 0, 1, 1, 0, 32'h20, 32'd7, 5'd0);
        exec(0, 1, 0, 1, 1, 32'h20, 32'h0, 5'd7);
        // reset in the second WAIT cycle of a store abandons the write
        exec(0, 0, 1, 0, 0, 32'h30, 32'h11, 5'd0);
        drive(0, 0, 1, 0, 0, 32'h30, 32'h55, 5'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 0;
        model_reset();
        #1 check_outs(0, "midwait_rst");
        @(posedge clk); #1;
        check_outs(0, "midwait_rst_hold");
        rst_n = 1;
        exec(0, 1, 0, 1, 1, 32'h30, 32'h0, 5'd12);

        park(0);
        // zero latency: loads/stores never stall
        exec(1, 0, 1, 0, 0, 32'h40, 32'h0BAD_F00D, 5'd0);
        exec(1, 0, 1, 0, 0, 32'h44, 32'h1357_9BDF, 5'd0);
        exec(1, 1, 0, 1, 1, 32'h40, 32'h0, 5'd1);
        exec(1, 1, 0, 1, 1, 32'h44, 32'h0, 5'd2);
        exec(1, 1, 0, 1, 1, 32'h140, 32'h0, 5'd3);
        exec(1, 1, 0, 0, 0, 32'hCAFE, 32'h0, 5'd9);

        // randomized blocks, alternating between the two DUTs
        for (int b = 0; b < 6; b++) begin
            int s;
            s = b % 2;
            park(1 - s);
            for (int i = 0; i < 15; i++) rand_op(s);
        end

`ifdef MEM_STATS_EN
        for (int s = 0; s < 2; s++) begin
            check_eq("load_count", lc[s], 32'(m_loads[s]));
            check_eq("store_count", sc[s], 32'(m_stores[s]));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
